// File: rtl/ex_hazard_ctrl.sv
// Execute-stage forwarding and load-use hazard controller.
// Tracks in-flight destination registers and registers the EX forward selects.
module ex_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_Rn,
  input  logic [4:0]       id_Rm,
  input  logic             id_uses_Rn,
  input  logic             id_uses_Rm,
  input  logic [4:0]       id_Rd,
  input  logic             id_RegWrite,
  input  logic             id_MemRead,
  input  logic             flush,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB,
  output logic             stall,
  output logic             ex_bubble,
  output logic [CNT_W-1:0] stall_count
);

  // Handshake: an ID instruction moves into EX on a rising edge exactly when
  // id_valid & ~flush & ~stall; otherwise EX receives a bubble.

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  logic       ex_valid, ex_regwrite, ex_memread;
  logic [4:0] ex_rd;
  logic       mem_valid, mem_regwrite;
  logic [4:0] mem_rd;

  logic       issue;
  logic       ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic [1:0] fwd_a_next, fwd_b_next;

  // X31 reads as zero, so a write to it must never be forwarded.
  function automatic logic writes(input logic v, input logic rw,
                                  input logic [4:0] rd, input logic [4:0] src);
    return v & rw & (rd == src) & (src != 5'd31);
  endfunction

  assign ex_hit_a  = id_uses_Rn & writes(ex_valid,  ex_regwrite,  ex_rd,  id_Rn);
  assign ex_hit_b  = id_uses_Rm & writes(ex_valid,  ex_regwrite,  ex_rd,  id_Rm);
  assign mem_hit_a = id_uses_Rn & writes(mem_valid, mem_regwrite, mem_rd, id_Rn);
  assign mem_hit_b = id_uses_Rm & writes(mem_valid, mem_regwrite, mem_rd, id_Rm);

  assign stall = id_valid & ~flush & ex_memread & (ex_hit_a | ex_hit_b);
  assign issue = id_valid & ~flush & ~stall;

  always_comb begin
    fwd_a_next = FWD_RF;
    fwd_b_next = FWD_RF;
    if (issue) begin
      if (ex_hit_a)       fwd_a_next = FWD_MEM;
      else if (mem_hit_a) fwd_a_next = FWD_WB;
      if (ex_hit_b)       fwd_b_next = FWD_MEM;
      else if (mem_hit_b) fwd_b_next = FWD_WB;
    end
  end

  // A WB-stage writer needs no shadow entry: the register file resolves it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      ex_rd        <= 5'd0;
      mem_valid    <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_rd       <= 5'd0;
      forwardA     <= FWD_RF;
      forwardB     <= FWD_RF;
      ex_bubble    <= 1'b1;
      stall_count  <= '0;
    end else begin
      mem_valid    <= ex_valid;
      mem_regwrite <= ex_regwrite;
      mem_rd       <= ex_rd;
      ex_valid     <= issue;
      ex_regwrite  <= id_RegWrite;
      ex_memread   <= id_MemRead;
      ex_rd        <= id_Rd;
      forwardA     <= fwd_a_next;
      forwardB     <= fwd_b_next;
      ex_bubble    <= ~issue;
      if (stall && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/ex_hazard_ctrl.md
# ex_hazard_ctrl

Forwarding and hazard controller for the execute stage of the pipelined CPU. It keeps a shadow record of the destination registers of in-flight instructions in EX, MEM and WB. From that record it registers the `forwardA`/`forwardB` selects consumed by the EX datapath, and detects load-use hazards. On a hazard it stalls fetch/decode for one cycle, injects a bubble into EX, and counts stall cycles.

## Interface
Parameters:
- `CNT_W`, 32, width of the saturating stall-cycle counter.

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_Rn`  in  5  first source register of the ID instruction.
- `id_Rm`  in  5  second source register of the ID instruction.
- `id_uses_Rn`  in  1  ALU A input comes from Rn.
- `id_uses_Rm`  in  1  ALU B input comes from Rm (ALUsrc selects register).
- `id_Rd`  in  5  destination register of the ID instruction.
- `id_RegWrite`  in  1  ID instruction writes Rd.
- `id_MemRead`  in  1  ID instruction is a load.
- `flush`  in  1  taken branch; discard the ID instruction.
- `forwardA`  out  2  registered EX select for A: 00 regfile, 01 alu_result_mem, 10 alu_result_wb.
- `forwardB`  out  2  registered EX select for B, same encoding.
- `stall`  out  1  combinational; hold PC and IF/ID this cycle.
- `ex_bubble`  out  1  registered; EX slot holds no instruction.
- `stall_count`  out  CNT_W  saturating count of stall cycles.

## Operation
- Shadow pipeline: three entries (EX, MEM, WB), each {valid, rd, regwrite, memread}. Every cycle WB←MEM and MEM←EX. EX←ID fields when `id_valid & ~stall & ~flush`; otherwise EX.valid←0.
- "Writer match" for entry E and source S: `E.valid & E.regwrite & E.rd==S & S!=31`. X31 (XZR) never matches.
- Next forward select for A, computed in ID and registered into EX:
  - `id_uses_Rn` and the current EX entry matches Rn → 01. The writer will sit in MEM when the consumer is in EX.
  - Otherwise, current MEM entry matches → 10.
  - Otherwise → 00.
- Same rule for B using Rm and `id_uses_Rm`. When `id_uses_Rm`=0, the B select is 00 so it never overrides an immediate.
- The EX-match priority over MEM guarantees the newest value wins.
- A WB-stage writer is not forwarded: the register file resolves the same-cycle write/read.
- Load-use hazard: `stall = id_valid & ~flush & EX.valid & EX.memread & EX.regwrite & ((id_uses_Rn & EX.rd==id_Rn) | (id_uses_Rm & EX.rd==id_Rm))`, with the rd≠31 condition applied.
- Stalled cycle:
  - EX gets a bubble and the registered forwards become 00.
  - The ID instruction is re-evaluated next cycle. The load is now in MEM, so the consumer gets select 10.
- `flush` has priority over `stall`: with `flush`=1, `stall`=0, EX gets a bubble and forwards become 00.
- `stall_count` increments on every cycle with `stall`=1 and saturates at all ones.

## Timing
- Reset (async, immediate):
  - all entries invalid;
  - `forwardA`=`forwardB`=00, `ex_bubble`=1, `stall_count`=0;
  - `stall`=0, because the EX entry is invalid.
- Forward selects are valid one cycle after the instruction is presented in ID, i.e. while it is in EX.
- `stall` depends only on current ID inputs and the EX entry. The maximum stall per load-use pair is 1 cycle.
- Back-to-back consumers of the same load: only the first stalls. The second sees the load in WB and gets 00 via the regfile.
- Reset asserted mid-stall: state clears immediately, and the held ID instruction is re-presented after reset by the fetch logic.

## Test plan
- **Reset:** assert `reset` with a load of X3 in flight → `forwardA/B`=00, `ex_bubble`=1, `stall`=0, `stall_count`=0 without waiting for a clock.
- **EX→EX forward:** ADD X1 (Rd=1) then SUB Rn=1, Rm=2 on consecutive cycles → SUB in EX sees `forwardA`=01, `forwardB`=00.
- **MEM forward and priority:**
  - ADD X4; then unrelated op; then consumer Rm=4 with `id_uses_Rm`=1 → `forwardB`=10.
  - Two writers of X4 back-to-back, then consumer → `forwardB`=01 (newest wins).
- **Load-use:** LDUR X5, then ADD Rn=5 →
  - `stall`=1 for exactly one cycle and `ex_bubble`=1 next cycle;
  - the ADD then enters EX with `forwardA`=10;
  - `stall_count`=1.
- **XZR and immediate:**
  - writer Rd=31 followed by consumer Rn=31 → `forwardA`=00, no stall.
  - consumer with `id_uses_Rm`=0 whose Rm field matches the EX Rd → `forwardB`=00.
- **Flush vs stall:** present the load-use pattern with `flush`=1 in the hazard cycle → `stall`=0, EX bubble, `stall_count` unchanged.
